// File: rtl/haar_pkg.sv
// Shared encodings for the Haar classifier: feature modes, one-hot FSM
// states and 3x3 corner-grid point indices (k = 3*row + col).
package haar_pkg;

    localparam logic [1:0] MODE_VERT  = 2'd0;
    localparam logic [1:0] MODE_HORZ  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;

    localparam int ST_IDLE_B    = 0;
    localparam int ST_PREP_B    = 1;
    localparam int ST_FETCH_B   = 2;
    localparam int ST_COMPUTE_B = 3;
    localparam int ST_DONE_B    = 4;

    localparam logic [4:0] ST_IDLE    = 5'b00001;
    localparam logic [4:0] ST_PREP    = 5'b00010;
    localparam logic [4:0] ST_FETCH   = 5'b00100;
    localparam logic [4:0] ST_COMPUTE = 5'b01000;
    localparam logic [4:0] ST_DONE    = 5'b10000;

    localparam int GRID_POINTS = 9;

    localparam int P00 = 0;
    localparam int P01 = 1;
    localparam int P02 = 2;
    localparam int P10 = 3;
    localparam int P11 = 4;
    localparam int P12 = 5;
    localparam int P20 = 6;
    localparam int P21 = 7;
    localparam int P22 = 8;

endpackage

// File: rtl/haar_multi_classifier_if.sv
// Request/read bus between detection_sm, the classifier and the
// integral-image buffer.
interface haar_multi_classifier_if #(
    parameter int DATA_W = 21,
    parameter int ADDR_W = 15
);
    logic                     detect_en;
    logic                     detect_done;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] data_in;

    modport master (
        output detect_en,
        output data_in,
        input  detect_done,
        input  rd_addr
    );

    modport slave (
        input  detect_en,
        input  data_in,
        output detect_done,
        output rd_addr
    );
endinterface

// File: rtl/haar_grid_addr.sv
// Corner-grid address generator: 9 buffer addresses plus a window
// validity flag, addresses captured when load_i is high.
module haar_grid_addr
    import haar_pkg::*;
#(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [7:0]        win_x_i,
    input  logic [6:0]        win_y_i,
    input  logic [7:0]        win_w_i,
    input  logic [6:0]        win_h_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_d_o [GRID_POINTS],
    output logic [ADDR_W-1:0] addr_o   [GRID_POINTS]
);
    logic [9:0] row [3];
    logic [9:0] col [3];

    always_comb begin
        row[0] = 10'(win_y_i);
        row[1] = 10'(win_y_i) + 10'(win_h_i >> 1);
        row[2] = 10'(win_y_i) + 10'(win_h_i) - 10'd1;
        col[0] = 10'(win_x_i);
        col[1] = 10'(win_x_i) + 10'(win_w_i >> 1);
        col[2] = 10'(win_x_i) + 10'(win_w_i) - 10'd1;
        // Width/height guards come first so a wrapped far edge never passes
        valid_o = (win_w_i >= 8'd2) && (win_h_i >= 7'd2)
                  && (32'(col[2]) < II_WIDTH)
                  && (32'(row[2]) < II_HEIGHT);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                addr_d_o[3*i+j] = ADDR_W'(32'(row[i]) * 32'(II_WIDTH)
                                          + 32'(col[j]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < GRID_POINTS; k++) begin
                addr_o[k] <= '0;
            end
        end else if (load_i) begin
            for (int k = 0; k < GRID_POINTS; k++) begin
                addr_o[k] <= addr_d_o[k];
            end
        end
    end
endmodule

// File: rtl/haar_multi_classifier.sv
// Haar rectangle-feature classifier: fetches a 3x3 integral-image corner
// grid, scores one of three features and compares against a threshold.
module haar_multi_classifier
    import haar_pkg::*;
#(
    parameter int II_WIDTH   = 160,
    parameter int II_HEIGHT  = 120,
    parameter int DATA_W     = 21,
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 3,
    parameter int THR_INIT   = 500,
    parameter int THR_STEP   = 100,
    parameter int THR_MAX    = 288000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     increment_threshold,
    input  logic                     decrement_threshold,
    input  logic [1:0]               mode,
    input  logic [7:0]               win_x,
    input  logic [6:0]               win_y,
    input  logic [7:0]               win_w,
    input  logic [6:0]               win_h,
    haar_multi_classifier_if.slave   bus,
    output logic                     detected_flag,
    output logic signed [DATA_W+2:0] score,
    output logic                     config_err,
    output logic signed [DATA_W-1:0] threshold
);
    localparam int SW = DATA_W + 3;
    localparam logic [7:0] LAT8   = 8'(RD_LATENCY);
    localparam logic [7:0] LASTPT = 8'(GRID_POINTS - 1);
    localparam logic [7:0] LAST8  = 8'(GRID_POINTS - 1 + RD_LATENCY);
    localparam logic signed [DATA_W+1:0] STEP_W = (DATA_W+2)'(THR_STEP);
    localparam logic signed [DATA_W+1:0] MAX_W  = (DATA_W+2)'(THR_MAX);
    localparam logic signed [DATA_W+1:0] ZERO_W = '0;

    logic [4:0]               state_q, state_d;
    logic                     en_q, start;
    logic [1:0]               mode_q;
    logic [7:0]               win_x_q, win_w_q;
    logic [6:0]               win_y_q, win_h_q;
    logic signed [DATA_W-1:0] thr_q, thr_d, thr_lat_q;
    logic signed [DATA_W+1:0] thr_x, thr_up, thr_dn;
    logic signed [SW-1:0]     thr_ext;
    logic [7:0]               cnt_q;
    logic [3:0]               nxt_idx, cap_idx;
    logic signed [DATA_W-1:0] pt_q [GRID_POINTS];
    logic signed [SW-1:0]     p    [GRID_POINTS];
    logic signed [SW-1:0]     feat_d, score_q;
    logic                     flag_q, err_q;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic                     grid_ok;
    logic [ADDR_W-1:0]        addr_d [GRID_POINTS];
    logic [ADDR_W-1:0]        addr_q [GRID_POINTS];

    function automatic logic signed [SW-1:0] rect(
        input logic signed [SW-1:0] ac,
        input logic signed [SW-1:0] ad,
        input logic signed [SW-1:0] bc,
        input logic signed [SW-1:0] bd
    );
        return bd - ad - bc + ac;
    endfunction

    haar_grid_addr #(
        .II_WIDTH  (II_WIDTH),
        .II_HEIGHT (II_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_grid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (state_q[ST_PREP_B]),
        .win_x_i  (win_x_q),
        .win_y_i  (win_y_q),
        .win_w_i  (win_w_q),
        .win_h_i  (win_h_q),
        .valid_o  (grid_ok),
        .addr_d_o (addr_d),
        .addr_o   (addr_q)
    );

    assign start   = bus.detect_en & ~en_q & state_q[ST_IDLE_B];
    assign nxt_idx = cnt_q[3:0] + 4'd1;
    assign cap_idx = 4'(cnt_q - LAT8);
    assign thr_ext = {{3{thr_lat_q[DATA_W-1]}}, thr_lat_q};

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[ST_IDLE_B]:    if (start) state_d = ST_PREP;
            state_q[ST_PREP_B]:    state_d = grid_ok ? ST_FETCH : ST_DONE;
            state_q[ST_FETCH_B]:   if (cnt_q == LAST8) state_d = ST_COMPUTE;
            state_q[ST_COMPUTE_B]: state_d = ST_DONE;
            state_q[ST_DONE_B]:    state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        thr_x  = {{2{thr_q[DATA_W-1]}}, thr_q};
        thr_up = thr_x + STEP_W;
        thr_dn = thr_x - STEP_W;
        thr_d  = thr_q;
        if (increment_threshold && !decrement_threshold && thr_up < MAX_W)
            thr_d = thr_up[DATA_W-1:0];
        else if (decrement_threshold && !increment_threshold
                 && thr_dn > ZERO_W)
            thr_d = thr_dn[DATA_W-1:0];
    end

    always_comb begin
        for (int k = 0; k < GRID_POINTS; k++) begin
            p[k] = {{3{pt_q[k][DATA_W-1]}}, pt_q[k]};
        end
    end

    always_comb begin
        feat_d = '0;
        unique case (mode_q)
            MODE_HORZ:
                feat_d = rect(p[P00], p[P01], p[P20], p[P21])
                       - rect(p[P01], p[P02], p[P21], p[P22]);
            MODE_CHECK:
                feat_d = rect(p[P00], p[P01], p[P10], p[P11])
                       + rect(p[P11], p[P12], p[P21], p[P22])
                       - rect(p[P01], p[P02], p[P11], p[P12])
                       - rect(p[P10], p[P11], p[P20], p[P21]);
            default:
                feat_d = rect(p[P00], p[P02], p[P10], p[P12])
                       - rect(p[P10], p[P12], p[P20], p[P22]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            mode_q    <= MODE_VERT;
            win_x_q   <= '0;
            win_y_q   <= '0;
            win_w_q   <= '0;
            win_h_q   <= '0;
            thr_q     <= DATA_W'(THR_INIT);
            thr_lat_q <= DATA_W'(THR_INIT);
            cnt_q     <= '0;
            rd_addr_q <= '0;
            score_q   <= '0;
            flag_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < GRID_POINTS; k++) begin
                pt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            en_q    <= bus.detect_en;
            thr_q   <= thr_d;
            if (start) begin
                mode_q    <= mode;
                win_x_q   <= win_x;
                win_y_q   <= win_y;
                win_w_q   <= win_w;
                win_h_q   <= win_h;
                thr_lat_q <= thr_q;
            end
            if (state_q[ST_PREP_B]) begin
                cnt_q <= '0;
                err_q <= ~grid_ok;
                if (grid_ok) begin
                    rd_addr_q <= addr_d[P00];
                end else begin
                    score_q <= '0;
                    flag_q  <= 1'b0;
                end
            end
            // Address k leaves in cnt k; its data returns RD_LATENCY later
            if (state_q[ST_FETCH_B]) begin
                cnt_q     <= cnt_q + 8'd1;
                rd_addr_q <= (cnt_q < LASTPT) ? addr_q[nxt_idx] : '0;
                if (cnt_q >= LAT8) pt_q[cap_idx] <= bus.data_in;
            end
            if (state_q[ST_COMPUTE_B]) begin
                score_q <= feat_d;
                flag_q  <= feat_d > thr_ext;
            end
        end
    end

    assign bus.detect_done = state_q[ST_DONE_B];
    assign bus.rd_addr     = rd_addr_q;
    assign detected_flag   = flag_q;
    assign score           = score_q;
    assign config_err      = err_q;
    assign threshold       = thr_q;
endmodule

// File: tb/tb_haar_multi_classifier.sv
// Directed bench: three classifiers (read latency 1, 3, 5) share the
// stimulus; each has its own latency-matched integral-image model.
module tb_haar_multi_classifier;
    localparam int DW = 21;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic den = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] wx = 8'd0;
    logic [7:0] ww = 8'd0;
    logic [6:0] wy = 7'd0;
    logic [6:0] wh = 7'd0;
    int img_sel = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    haar_multi_classifier_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
    haar_multi_classifier_if #(.DATA_W(DW), .ADDR_W(AW)) b3 ();
    haar_multi_classifier_if #(.DATA_W(DW), .ADDR_W(AW)) b5 ();

    logic flag1, flag3, flag5, err1, err3, err5;
    logic signed [DW+2:0] sc1, sc3, sc5;
    logic signed [DW-1:0] thr1, thr3, thr5;
    logic [AW-1:0] p1 [5];
    logic [AW-1:0] p3 [5];
    logic [AW-1:0] p5 [5];

    function automatic logic signed [DW-1:0] img(input logic [AW-1:0] a,
                                                 input int sel);
        int r, c, v;
        r = int'(a) / 160;
        c = int'(a) % 160;
        if (sel == 0) v = (r + 1) * (c + 1);
        else v = 10 * (c + 1) * ((r < 60) ? r + 1 : 60);
        return DW'(v);
    endfunction

    always @(posedge clk) begin
        p1[0] <= b1.rd_addr;
        p3[0] <= b3.rd_addr;
        p5[0] <= b5.rd_addr;
        for (int i = 1; i < 5; i++) begin
            p1[i] <= p1[i-1];
            p3[i] <= p3[i-1];
            p5[i] <= p5[i-1];
        end
    end

    assign b1.detect_en = den;
    assign b3.detect_en = den;
    assign b5.detect_en = den;
    assign b1.data_in = img(p1[0], img_sel);
    assign b3.data_in = img(p3[2], img_sel);
    assign b5.data_in = img(p5[4], img_sel);

    haar_multi_classifier #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .increment_threshold(inc), .decrement_threshold(dec),
        .mode(mode), .win_x(wx), .win_y(wy), .win_w(ww), .win_h(wh),
        .bus(b1.slave), .detected_flag(flag1), .score(sc1),
        .config_err(err1), .threshold(thr1));

    haar_multi_classifier #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .increment_threshold(inc), .decrement_threshold(dec),
        .mode(mode), .win_x(wx), .win_y(wy), .win_w(ww), .win_h(wh),
        .bus(b3.slave), .detected_flag(flag3), .score(sc3),
        .config_err(err3), .threshold(thr3));

    haar_multi_classifier #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(5)) u5 (
        .clk(clk), .rst(rst),
        .increment_threshold(inc), .decrement_threshold(dec),
        .mode(mode), .win_x(wx), .win_y(wy), .win_w(ww), .win_h(wh),
        .bus(b5.slave), .detected_flag(flag5), .score(sc5),
        .config_err(err5), .threshold(thr5));

    int dc1, dc3, dc5, nd3;
    logic nz3;
    logic [AW-1:0] aseq [9];

    // Cycle 0 is the cycle in which detect_en first rises.
    task automatic run_det(input logic [1:0] m, input logic [7:0] x,
                           input logic [6:0] y, input logic [7:0] w,
                           input logic [6:0] h);
        @(posedge clk); #1;
        mode = m; wx = x; wy = y; ww = w; wh = h; den = 1'b1;
        dc1 = -1; dc3 = -1; dc5 = -1; nd3 = 0; nz3 = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            den = 1'b0;
            if (b1.detect_done && dc1 < 0) dc1 = c;
            if (b3.detect_done && dc3 < 0) dc3 = c;
            if (b5.detect_done && dc5 < 0) dc5 = c;
            if (b3.detect_done) nd3++;
            if (b3.rd_addr != '0) nz3 = 1'b1;
            if (c >= 2 && c <= 10) aseq[c-2] = b3.rd_addr;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (b3.detect_done !== 1'b0) begin bad++;
            $display("FAIL rst_done got=%0b want=0", b3.detect_done); end
        total++; if (b3.rd_addr !== '0) begin bad++;
            $display("FAIL rst_addr got=%0d want=0", b3.rd_addr); end
        total++; if (flag3 !== 1'b0) begin bad++;
            $display("FAIL rst_flag got=%0b want=0", flag3); end
        total++; if (sc3 !== '0) begin bad++;
            $display("FAIL rst_score got=%0d want=0", sc3); end
        total++; if (err3 !== 1'b0) begin bad++;
            $display("FAIL rst_err got=%0b want=0", err3); end
        total++; if (int'(thr3) !== 500) begin bad++;
            $display("FAIL rst_thr got=%0d want=500", thr3); end
        rst = 1'b0;
    endtask

    task automatic test_uniform;
        int exp_s [4] = '{159, 119, 1, 159};
        img_sel = 0;
        for (int m = 0; m < 4; m++) begin
            run_det(2'(m), 8'd0, 7'd0, 8'd160, 7'd120);
            total++; if (int'(sc3) !== exp_s[m]) begin bad++;
                $display("FAIL uni_m%0d_score got=%0d want=%0d",
                         m, sc3, exp_s[m]); end
            total++; if (flag3 !== 1'b0) begin bad++;
                $display("FAIL uni_m%0d_flag got=%0b want=0", m, flag3); end
            total++; if (dc3 !== 15) begin bad++;
                $display("FAIL uni_m%0d_done got=%0d want=15", m, dc3); end
            if (m < 3) begin
                total++; if (dc1 !== 13) begin bad++;
                    $display("FAIL lat1_m%0d_done got=%0d want=13", m, dc1); end
                total++; if (int'(sc1) !== exp_s[m]) begin bad++;
                    $display("FAIL lat1_m%0d_score got=%0d want=%0d",
                             m, sc1, exp_s[m]); end
                total++; if (dc5 !== 17) begin bad++;
                    $display("FAIL lat5_m%0d_done got=%0d want=17", m, dc5); end
                total++; if (int'(sc5) !== exp_s[m]) begin bad++;
                    $display("FAIL lat5_m%0d_score got=%0d want=%0d",
                             m, sc5, exp_s[m]); end
            end
        end
    endtask

    task automatic test_top_rows;
        int exp_a [9] = '{0, 80, 159, 9600, 9680, 9759, 19040, 19120, 19199};
        img_sel = 1;
        run_det(2'd0, 8'd0, 7'd0, 8'd160, 7'd120);
        total++; if (int'(sc3) !== 93810) begin bad++;
            $display("FAIL top_score got=%0d want=93810", sc3); end
        total++; if (flag3 !== 1'b1) begin bad++;
            $display("FAIL top_flag got=%0b want=1", flag3); end
        total++; if (dc3 !== 15) begin bad++;
            $display("FAIL top_done got=%0d want=15", dc3); end
        for (int k = 0; k < 9; k++) begin
            total++; if (int'(aseq[k]) !== exp_a[k]) begin bad++;
                $display("FAIL top_addr%0d got=%0d want=%0d",
                         k, aseq[k], exp_a[k]); end
        end
    endtask

    task automatic test_invalid;
        img_sel = 0;
        run_det(2'd0, 8'd100, 7'd0, 8'd80, 7'd120);
        total++; if (dc3 !== 2) begin bad++;
            $display("FAIL inv_done got=%0d want=2", dc3); end
        total++; if (err3 !== 1'b1) begin bad++;
            $display("FAIL inv_err got=%0b want=1", err3); end
        total++; if (flag3 !== 1'b0) begin bad++;
            $display("FAIL inv_flag got=%0b want=0", flag3); end
        total++; if (sc3 !== '0) begin bad++;
            $display("FAIL inv_score got=%0d want=0", sc3); end
        total++; if (nz3 !== 1'b0) begin bad++;
            $display("FAIL inv_addr got=%0b want=0", nz3); end
    endtask

    task automatic test_reset_mid;
        int n;
        img_sel = 1;
        run_det(2'd0, 8'd0, 7'd0, 8'd160, 7'd120);
        @(posedge clk); #1;
        den = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            den = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (b3.detect_done !== 1'b0) begin bad++;
            $display("FAIL mid_done got=%0b want=0", b3.detect_done); end
        total++; if (b3.rd_addr !== '0) begin bad++;
            $display("FAIL mid_addr got=%0d want=0", b3.rd_addr); end
        total++; if (sc3 !== '0) begin bad++;
            $display("FAIL mid_score got=%0d want=0", sc3); end
        total++; if (flag3 !== 1'b0) begin bad++;
            $display("FAIL mid_flag got=%0b want=0", flag3); end
        n = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (b3.detect_done) n++;
        end
        total++; if (n !== 0) begin bad++;
            $display("FAIL mid_nodone got=%0d want=0", n); end
        total++; if (int'(thr3) !== 500) begin bad++;
            $display("FAIL mid_thr got=%0d want=500", thr3); end
    endtask

    task automatic test_held_high;
        int n;
        img_sel = 0;
        @(posedge clk); #1;
        mode = 2'd0; wx = 8'd0; wy = 7'd0; ww = 8'd160; wh = 7'd120;
        den = 1'b1;
        n = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (b3.detect_done) n++;
        end
        den = 1'b0;
        total++; if (n !== 1) begin bad++;
            $display("FAIL held_dones got=%0d want=1", n); end
    endtask

    task automatic pulse(input logic i, input logic d);
        @(posedge clk); #1;
        inc = i; dec = d;
        @(posedge clk); #1;
        inc = 1'b0; dec = 1'b0;
    endtask

    task automatic test_threshold;
        repeat (3) pulse(1'b1, 1'b0);
        total++; if (int'(thr3) !== 800) begin bad++;
            $display("FAIL thr_inc got=%0d want=800", thr3); end
        pulse(1'b1, 1'b1);
        total++; if (int'(thr3) !== 800) begin bad++;
            $display("FAIL thr_both got=%0d want=800", thr3); end
        repeat (7) pulse(1'b0, 1'b1);
        total++; if (int'(thr3) !== 100) begin bad++;
            $display("FAIL thr_dec got=%0d want=100", thr3); end
        pulse(1'b0, 1'b1);
        total++; if (int'(thr3) !== 100) begin bad++;
            $display("FAIL thr_floor got=%0d want=100", thr3); end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_top_rows();
        test_reset_mid();
        test_invalid();
        test_held_high();
        test_threshold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
